arm_dp_issue: RTL and testbench
===============================

Name: arm_dp_issue

Overview:
- Issue and flag-commit stage for ARM data-processing instructions, and the producer and consumer of the team's combinational ALU.
- Decodes an accepted instruction and builds operand 2 through a barrel shifter.
- Evaluates the condition field against forwarded NZCV and drives the ALU inputs from registers.
- Captures the ALU result and flags into write-back and CPSR-flag registers.

Parameters:
- None. Widths are fixed by the architecture: 32-bit data, 4-bit register address.

Ports:
clk  in  1  system clock; all flops on rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  equals (state==IDLE)
instr  in  32  ARM instruction word
rn_data  in  32  Rn value, valid with instr_valid
rm_data  in  32  Rm value, valid with instr_valid
rs_addr  out  4  Rs read address, registered
rs_data  in  32  Rs value, async register-file read of rs_addr
alu_op1  out  32  registered, to ALU
alu_op2  out  32  registered, to ALU
alu_op_sel  out  4  registered, equals instr[24:21]
alu_valid  out  1  E stage holds a condition-passed instruction
alu_out  in  32  ALU result, combinational
n_bit  in  1  ALU N flag
z_bit  in  1  ALU Z flag
c_bit  in  1  ALU C flag
v_bit  in  1  ALU V flag
wb_valid  out  1  write-back strobe
wb_addr  out  4  destination Rd
wb_data  out  32  write-back data
flags_nzcv  out  4  committed flags {N,Z,C,V}

Behaviour:
- Reset: every flop cleared.
  - Cleared outputs: flags_nzcv=0000, alu_op1=alu_op2=0, alu_op_sel=0, alu_valid=0, wb_valid=0, wb_addr=0, wb_data=0, rs_addr=0.
  - State=IDLE. Instructions presented while rst_n is low are ignored.
  - Reset mid-RS_FETCH drops the held instruction.
- FSM states IDLE, RS_FETCH. A handshake occurs when instr_valid && instr_ready.
- IDLE:
  - If the handshake occurs and the instruction is register-shift-by-register (I=0, bit4=1, bit7=0), latch instr, rn_data and rm_data, set rs_addr=instr[11:8], and go to RS_FETCH.
  - Otherwise the instruction issues into E at that edge.
- RS_FETCH (exactly one cycle): sample rs_data, issue into E, return to IDLE.
- Timing: handshake in cycle t, alu_valid in t+1, wb_valid and flags_nzcv update visible in t+2. Register-shift instructions add one cycle.
- No downstream backpressure. Rn/Rm hazards against pending write-back are upstream's responsibility.
- Condition: all 15 ARM codes (EQ..AL); NV is treated as fail.
  - Evaluated in the issue cycle against forwarded flags: if E holds alu_valid with S=1, use E's computed next-flags, otherwise flags_nzcv.
  - Fail: E loads a bubble (alu_valid=0): no write-back, no flag change.
- NOPs: accepted, no effect. This covers:
  - non-DP space, i.e. instr[27:26]!=00, or I=0 && bit4=1 && bit7=1;
  - opcodes 8..11 with S=0.
- Operand 2 (shifter carry-out `sc`; C means the current forwarded C):
  - Immediate: imm8 ROR 2*rot; sc = (rot==0) ? C : op2[31].
  - Shift by immediate:
    - LSL#0: Rm, sc=C.
    - LSR#0 means LSR#32: op2=0, sc=Rm[31].
    - ASR#0 means ASR#32: op2 is all Rm[31], sc=Rm[31].
    - ROR#0 means RRX: op2={C,Rm[31:1]}, sc=Rm[0].
  - Shift by register, amount a = Rs[7:0]:
    - a==0: Rm, sc=C.
    - LSL/LSR, a==32: op2=0, sc=Rm[0] for LSL, Rm[31] for LSR.
    - LSL/LSR, a>32: op2=0, sc=0.
    - ASR, a>=32: op2 is all Rm[31], sc=Rm[31].
    - ROR, a[4:0]==0 with a!=0: Rm, sc=Rm[31]; otherwise rotate by a[4:0].
- E stage registers: op1=Rn, op2, op_sel, S, Rd, sc, and an is_arith flag (opcodes 2..7, 10, 11).
- Write-back: at the end of E when alu_valid and the opcode is not TST/TEQ/CMP/CMN, wb_data=alu_out and wb_addr=Rd. Rd=15 is not special-cased.
- Flags: updated when alu_valid && S.
  - N=n_bit, Z=z_bit.
  - is_arith: C=c_bit, V=v_bit. Logical: C=sc, V unchanged.
  - The ALU gets no carry-in, so ADC/SBC/RSC behave as ADD/SUB/RSB; this is a fixed limitation of this block.

Decomposition:
- Package arm_defs:
  - opcode constants AND..MVN (0..15);
  - condition constants EQ..NV;
  - shift-type constants LSL/LSR/ASR/ROR;
  - instruction field bit positions.
- Sub-module: arm_shifter, combinational: (rm, amount[7:0], type, imm_form, c_in) -> (op2, sc). It is used for all three operand-2 forms.

Test Plan:
1. Reset -> flags_nzcv=0000, alu_valid=0, wb_valid=0, instr_ready=1.
2. MOVS r1,#0 (0xE3B01000) -> in t+1: op_sel=13, op2=0; in t+2: wb r1=0, flags=0100.
3. SUBS r2,r3,r4 (0xE0532004), rn=5, rm=7 -> wb r2=0xFFFFFFFE, flags=1000.
4. CMP r0,r0 (0xE1500000), rn=rm=3, then next cycle MOVEQ r5,#1 (0x03A05001) -> forwarded Z=1, wb r5=1. Repeat with rn=3, rm=4 -> MOVEQ bubble, no wb.
5. MOVS r0,r1,LSL r2 (0xE1B00211), rm=1:
   - instr_ready low for one cycle, rs_addr=2;
   - rs_data=33 -> op2=0, flags=0100;
   - rs_data=32 -> flags=0110.
6. MOVS r0,#0x80000000 (0xE3B00102) -> op2=0x80000000, flags=1010. Assert rst_n low during RS_FETCH -> no alu_valid, state IDLE.

Source files
------------

// File: rtl/arm_dp_issue_pkg.sv
// Shared definitions for the ARM data-processing issue stage.
// Contents: opcode, condition and shift-type constants, instruction field
// positions, the FSM state type, and small decode helpers (condition check,
// arithmetic-opcode classification).
package arm_defs;

  // Data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  // Condition codes (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // Shift types (instr[6:5])
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  // Instruction field positions
  localparam int COND_LSB  = 28;
  localparam int CLASS_LSB = 26;
  localparam int BIT_I     = 25;
  localparam int OPC_LSB   = 21;
  localparam int BIT_S     = 20;
  localparam int RD_LSB    = 12;
  localparam int RS_LSB    = 8;
  localparam int ROT_LSB   = 8;
  localparam int SHAMT_LSB = 7;
  localparam int BIT_7     = 7;
  localparam int SHTYP_LSB = 5;
  localparam int BIT_4     = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    RS_FETCH = 1'b1
  } state_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Opcodes whose C/V come from the adder rather than the shifter
  function automatic logic is_arith_op(input logic [3:0] op);
    return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/arm_dp_issue_if.sv
// Bundle of the issue stage's handshake, register-file and ALU signals.
// slave  : the issue stage (arm_dp_issue)
// master : the surrounding pipeline / register file / ALU
interface arm_dp_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rn_data;
  logic [31:0] rm_data;
  logic [3:0]  rs_addr;
  logic [31:0] rs_data;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_op_sel;
  logic        alu_valid;
  logic [31:0] alu_out;
  logic        n_bit;
  logic        z_bit;
  logic        c_bit;
  logic        v_bit;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  flags_nzcv;

  modport slave (
    input  instr_valid, instr, rn_data, rm_data, rs_data,
           alu_out, n_bit, z_bit, c_bit, v_bit,
    output instr_ready, rs_addr, alu_op1, alu_op2, alu_op_sel, alu_valid,
           wb_valid, wb_addr, wb_data, flags_nzcv
  );

  modport master (
    output instr_valid, instr, rn_data, rm_data, rs_data,
           alu_out, n_bit, z_bit, c_bit, v_bit,
    input  instr_ready, rs_addr, alu_op1, alu_op2, alu_op_sel, alu_valid,
           wb_valid, wb_addr, wb_data, flags_nzcv
  );
endinterface

// File: rtl/arm_shifter.sv
// Combinational ARM barrel shifter producing operand 2 and shifter carry-out.
// Ports:
//   rm         value to shift (imm8 zero-extended for the immediate form)
//   amount     shift amount (Rs[7:0], shamt5, or 2*rot)
//   shift_type LSL/LSR/ASR/ROR
//   imm_form   1 = shift-by-immediate encoding, where amount 0 is special
//   c_in       current (forwarded) C flag
//   op2, sc    shifted operand and shifter carry-out
// The immediate operand form is fed as ROR with imm_form=0: rotation 0 keeps
// C, any other rotation yields op2[31], which is exactly register-ROR.
module arm_shifter
  import arm_defs::*;
(
  input  logic [31:0] rm,
  input  logic [7:0]  amount,
  input  logic [1:0]  shift_type,
  input  logic        imm_form,
  input  logic        c_in,
  output logic [31:0] op2,
  output logic        sc
);

  logic [32:0] lsl_t;
  logic [32:0] lsr_t;
  logic [32:0] asr_t;
  logic [31:0] ror_t;

  always_comb begin
    // extra bit carries the last bit shifted out
    lsl_t = {1'b0, rm} << amount[4:0];
    lsr_t = {rm, 1'b0} >> amount[4:0];
    asr_t = $signed({rm, 1'b0}) >>> amount[4:0];
    ror_t = (rm >> amount[4:0]) | (rm << (6'd32 - {1'b0, amount[4:0]}));

    op2 = rm;
    sc  = c_in;

    if (imm_form && (amount == 8'd0)) begin
      case (shift_type)
        SH_LSL: begin op2 = rm;            sc = c_in;   end
        SH_LSR: begin op2 = 32'd0;         sc = rm[31]; end
        SH_ASR: begin op2 = {32{rm[31]}};  sc = rm[31]; end
        SH_ROR: begin op2 = {c_in, rm[31:1]}; sc = rm[0]; end
      endcase
    end else if (amount != 8'd0) begin
      case (shift_type)
        SH_LSL: begin
          if (amount < 8'd32) begin
            op2 = lsl_t[31:0];
            sc  = lsl_t[32];
          end else begin
            op2 = 32'd0;
            sc  = (amount == 8'd32) ? rm[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amount < 8'd32) begin
            op2 = lsr_t[32:1];
            sc  = lsr_t[0];
          end else begin
            op2 = 32'd0;
            sc  = (amount == 8'd32) ? rm[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amount < 8'd32) begin
            op2 = asr_t[32:1];
            sc  = asr_t[0];
          end else begin
            op2 = {32{rm[31]}};
            sc  = rm[31];
          end
        end
        SH_ROR: begin
          if (amount[4:0] == 5'd0) begin
            op2 = rm;
            sc  = rm[31];
          end else begin
            op2 = ror_t;
            sc  = ror_t[31];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/arm_dp_issue.sv
// Issue and flag-commit stage for ARM data-processing instructions.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         arm_dp_issue_if.slave: instruction handshake with Rn/Rm
//               operands, Rs read port, ALU operand/result signals,
//               write-back strobe and committed NZCV flags
// Register-shift-by-register instructions spend one extra cycle in RS_FETCH
// so that Rs can be read through the registered rs_addr.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready; non-RSR instructions issue on their handshake edge
// RS_FETCH | RSR instruction held, rs_data sampled, issues this cycle
module arm_dp_issue
  import arm_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  arm_dp_issue_if.slave bus
);

  state_t state_q, state_d;
  logic   instr_ready;

  logic [31:0] hold_instr_q, hold_rn_q, hold_rm_q;
  logic [3:0]  rs_addr_q;

  logic        alu_valid_q, e_s_q, e_sc_q, e_arith_q;
  logic [31:0] op1_q, op2_q;
  logic [3:0]  op_sel_q, e_rd_q;

  logic        wb_valid_q;
  logic [3:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [3:0]  flags_q;

  logic        in_rs_fetch;
  logic [31:0] src_instr, src_rn, src_rm;
  logic [3:0]  dec_cond, dec_op, dec_rd;
  logic        dec_i, dec_s, dec_b4, dec_b7, dec_dp;
  logic        is_nop, is_rsr, hs, issue, pass;
  logic [3:0]  next_nzcv, fwd_nzcv;

  logic [31:0] sh_rm, sh_op2;
  logic [7:0]  sh_amount;
  logic [1:0]  sh_type;
  logic        sh_imm_form, sh_sc;
  logic        unused_bits;

  assign in_rs_fetch = (state_q == RS_FETCH);
  assign src_instr   = in_rs_fetch ? hold_instr_q : bus.instr;
  assign src_rn      = in_rs_fetch ? hold_rn_q    : bus.rn_data;
  assign src_rm      = in_rs_fetch ? hold_rm_q    : bus.rm_data;

  assign dec_cond = src_instr[COND_LSB +: 4];
  assign dec_dp   = (src_instr[CLASS_LSB +: 2] == 2'b00);
  assign dec_i    = src_instr[BIT_I];
  assign dec_op   = src_instr[OPC_LSB +: 4];
  assign dec_s    = src_instr[BIT_S];
  assign dec_rd   = src_instr[RD_LSB +: 4];
  assign dec_b4   = src_instr[BIT_4];
  assign dec_b7   = src_instr[BIT_7];

  // Non-DP space, multiply/extension space, and compare ops without S
  assign is_nop = !dec_dp || (!dec_i && dec_b4 && dec_b7) ||
                  ((dec_op[3:2] == 2'b10) && !dec_s);
  assign is_rsr = !is_nop && !dec_i && dec_b4;

  assign hs    = bus.instr_valid && instr_ready;
  assign issue = in_rs_fetch || (hs && !is_rsr);

  // Flags the instruction in E will commit, forwarded to the issue cycle
  assign next_nzcv = {bus.n_bit, bus.z_bit,
                      e_arith_q ? bus.c_bit : e_sc_q,
                      e_arith_q ? bus.v_bit : flags_q[0]};
  assign fwd_nzcv  = (alu_valid_q && e_s_q) ? next_nzcv : flags_q;

  assign pass = issue && !is_nop && cond_pass(dec_cond, fwd_nzcv);

  always_comb begin
    sh_rm       = src_rm;
    sh_amount   = 8'd0;
    sh_type     = src_instr[SHTYP_LSB +: 2];
    sh_imm_form = 1'b0;
    if (dec_i) begin
      sh_rm     = {24'd0, src_instr[7:0]};
      sh_amount = {3'd0, src_instr[ROT_LSB +: 4], 1'b0};
      sh_type   = SH_ROR;
    end else if (dec_b4) begin
      sh_amount = bus.rs_data[7:0];
    end else begin
      sh_amount   = {3'd0, src_instr[SHAMT_LSB +: 5]};
      sh_imm_form = 1'b1;
    end
  end

  arm_shifter u_shifter (
    .rm         (sh_rm),
    .amount     (sh_amount),
    .shift_type (sh_type),
    .imm_form   (sh_imm_form),
    .c_in       (fwd_nzcv[1]),
    .op2        (sh_op2),
    .sc         (sh_sc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid && is_rsr) state_d = RS_FETCH;
      end
      RS_FETCH: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr_q <= '0;
      hold_rn_q    <= '0;
      hold_rm_q    <= '0;
      rs_addr_q    <= '0;
    end else if (hs && is_rsr) begin
      hold_instr_q <= bus.instr;
      hold_rn_q    <= bus.rn_data;
      hold_rm_q    <= bus.rm_data;
      rs_addr_q    <= bus.instr[RS_LSB +: 4];
    end
  end

  // E stage: a failed condition or a NOP leaves a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_sel_q    <= '0;
      e_s_q       <= 1'b0;
      e_rd_q      <= '0;
      e_sc_q      <= 1'b0;
      e_arith_q   <= 1'b0;
    end else begin
      alu_valid_q <= pass;
      if (pass) begin
        op1_q     <= src_rn;
        op2_q     <= sh_op2;
        op_sel_q  <= dec_op;
        e_s_q     <= dec_s;
        e_rd_q    <= dec_rd;
        e_sc_q    <= sh_sc;
        e_arith_q <= is_arith_op(dec_op);
      end
    end
  end

  // Write-back and flag commit; TST/TEQ/CMP/CMN only touch flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      wb_valid_q <= alu_valid_q && (op_sel_q[3:2] != 2'b10);
      if (alu_valid_q && (op_sel_q[3:2] != 2'b10)) begin
        wb_addr_q <= e_rd_q;
        wb_data_q <= bus.alu_out;
      end
      if (alu_valid_q && e_s_q) flags_q <= next_nzcv;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.rs_addr     = rs_addr_q;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.alu_op_sel  = op_sel_q;
  assign bus.alu_valid   = alu_valid_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.flags_nzcv  = flags_q;

  // Rn/Rm fields arrive as data; only Rs[7:0] feeds the shifter
  assign unused_bits = ^{src_instr[19:16], src_instr[3:0], bus.rs_data[31:8]};

endmodule

// File: tb/tb_arm_dp_issue.sv
module tb_arm_dp_issue;
  import arm_defs::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arm_dp_issue_if bus();

  arm_dp_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference combinational ALU (no carry-in)
  logic [31:0] a, b;
  logic [32:0] alu_wide;
  logic        alu_c, alu_v;
  always_comb begin
    a = bus.alu_op1;
    b = bus.alu_op2;
    alu_wide = 33'd0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.alu_op_sel)
      OP_AND, OP_TST: alu_wide = {1'b0, a & b};
      OP_EOR, OP_TEQ: alu_wide = {1'b0, a ^ b};
      OP_SUB, OP_SBC, OP_CMP: begin
        alu_wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        alu_c = alu_wide[32];
        alu_v = (a[31] != b[31]) && (alu_wide[31] != a[31]);
      end
      OP_RSB, OP_RSC: begin
        alu_wide = {1'b0, b} + {1'b0, ~a} + 33'd1;
        alu_c = alu_wide[32];
        alu_v = (a[31] != b[31]) && (alu_wide[31] != b[31]);
      end
      OP_ADD, OP_ADC, OP_CMN: begin
        alu_wide = {1'b0, a} + {1'b0, b};
        alu_c = alu_wide[32];
        alu_v = (a[31] == b[31]) && (alu_wide[31] != a[31]);
      end
      OP_ORR: alu_wide = {1'b0, a | b};
      OP_MOV: alu_wide = {1'b0, b};
      OP_BIC: alu_wide = {1'b0, a & ~b};
      default: alu_wide = {1'b0, ~b};
    endcase
  end
  assign bus.alu_out = alu_wide[31:0];
  assign bus.n_bit   = alu_wide[31];
  assign bus.z_bit   = (alu_wide[31:0] == 32'd0);
  assign bus.c_bit   = alu_c;
  assign bus.v_bit   = alu_v;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_t;
  wb_t wb_q[$];

  // Write-back scoreboard
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 32'(bus.wb_addr), 32'hFFFF_FFFF);
        end else begin
          e = wb_q.pop_front();
          chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
          chk("wb_data", bus.wb_data, e.data);
        end
      end
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] rn, input logic [31:0] rm);
    int waited = 0;
    bus.instr       = i;
    bus.rn_data     = rn;
    bus.rm_data     = rm;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.instr_ready) chk("send_timeout", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr, rn, rm, rs;
    bit          rsr;
    bit          exp_e;
    logic [3:0]  exp_op_sel;
    logic [31:0] exp_op2;
    bit          exp_wb;
    logic [3:0]  exp_rd;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    vec_t v;
    vecs[0]  = '{"movs_imm0",   32'hE3B01000, 0, 0, 0, 0, 1, 4'd13, 32'h0, 1, 4'd1, 32'h0, 4'b0100};
    vecs[1]  = '{"subs",        32'hE0532004, 5, 7, 0, 0, 1, 4'd2, 32'h7, 1, 4'd2, 32'hFFFFFFFE, 4'b1000};
    vecs[2]  = '{"adds_wrap",   32'hE2906001, 32'hFFFFFFFF, 0, 0, 0, 1, 4'd4, 32'h1, 1, 4'd6, 32'h0, 4'b0110};
    vecs[3]  = '{"lsr32_imm",   32'hE1B07021, 0, 32'h80000001, 0, 0, 1, 4'd13, 32'h0, 1, 4'd7, 32'h0, 4'b0110};
    vecs[4]  = '{"rrx",         32'hE1B08061, 0, 32'h3, 0, 0, 1, 4'd13, 32'h80000001, 1, 4'd8, 32'h80000001, 4'b1010};
    vecs[5]  = '{"tst",         32'hE3110000, 5, 0, 0, 0, 1, 4'd8, 32'h0, 0, 4'd0, 32'h0, 4'b0110};
    vecs[6]  = '{"cmp_nos_nop", 32'hE1400000, 1, 2, 0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'b0110};
    vecs[7]  = '{"movne_fail",  32'h13A09005, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'b0110};
    vecs[8]  = '{"asr_reg40",   32'hE1B0A251, 0, 32'h80000000, 40, 1, 1, 4'd13, 32'hFFFFFFFF, 1, 4'd10, 32'hFFFFFFFF, 4'b1010};
    vecs[9]  = '{"ror_reg32",   32'hE1B0B271, 0, 32'h80000001, 32, 1, 1, 4'd13, 32'h80000001, 1, 4'd11, 32'h80000001, 4'b1010};
    vecs[10] = '{"lsl_reg33",   32'hE1B00211, 0, 1, 33, 1, 1, 4'd13, 32'h0, 1, 4'd0, 32'h0, 4'b0100};
    vecs[11] = '{"lsl_reg32",   32'hE1B00211, 0, 1, 32, 1, 1, 4'd13, 32'h0, 1, 4'd0, 32'h0, 4'b0110};
    vecs[12] = '{"movs_rotimm", 32'hE3B00102, 0, 0, 0, 0, 1, 4'd13, 32'h80000000, 1, 4'd0, 32'h80000000, 4'b1010};
    vecs[13] = '{"ldr_nop",     32'hE5901000, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'b1010};
    vecs[14] = '{"lsl_imm4",    32'hE1B03201, 0, 32'hF0000001, 0, 0, 1, 4'd13, 32'h10, 1, 4'd3, 32'h10, 4'b0010};
    vecs[15] = '{"mov_nos",     32'hE3A04007, 0, 0, 0, 0, 1, 4'd13, 32'h7, 1, 4'd4, 32'h7, 4'b0010};
    vecs[16] = '{"lsr_imm8",    32'hE1B05421, 0, 32'h12345680, 0, 0, 1, 4'd13, 32'h00123456, 1, 4'd5, 32'h00123456, 4'b0010};
    vecs[17] = '{"adds_ovf",    32'hE2906001, 32'h7FFFFFFF, 0, 0, 0, 1, 4'd4, 32'h1, 1, 4'd6, 32'h80000000, 4'b1001};
    vecs[18] = '{"movs_keep_v", 32'hE3B01000, 0, 0, 0, 0, 1, 4'd13, 32'h0, 1, 4'd1, 32'h0, 4'b0101};

    bus.instr_valid = 1'b0;
    bus.instr   = '0;
    bus.rn_data = '0;
    bus.rm_data = '0;
    bus.rs_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("reset_flags",     32'(bus.flags_nzcv), 32'd0);
    chk("reset_alu_valid", 32'(bus.alu_valid), 32'd0);
    chk("reset_wb_valid",  32'(bus.wb_valid), 32'd0);
    chk("reset_ready",     32'(bus.instr_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      send(v.instr, v.rn, v.rm);
      if (v.rsr) begin
        chk({v.name, "_ready_low"}, 32'(bus.instr_ready), 32'd0);
        chk({v.name, "_rs_addr"}, 32'(bus.rs_addr), 32'(v.instr[11:8]));
        bus.rs_data = v.rs;
        @(posedge clk); #1;
      end
      chk({v.name, "_alu_valid"}, 32'(bus.alu_valid), 32'(v.exp_e));
      if (v.exp_e) begin
        chk({v.name, "_op2"}, bus.alu_op2, v.exp_op2);
        chk({v.name, "_op_sel"}, 32'(bus.alu_op_sel), 32'(v.exp_op_sel));
      end
      if (v.exp_wb) wb_q.push_back('{v.exp_rd, v.exp_data});
      @(posedge clk); #1;
      chk({v.name, "_flags"}, 32'(bus.flags_nzcv), 32'(v.exp_flags));
    end

    // Back-to-back CMP then MOVEQ: condition must see CMP's flags from E
    send(32'hE1500000, 3, 3);
    send(32'h03A05001, 0, 0);
    chk("fwd_eq_alu_valid", 32'(bus.alu_valid), 32'd1);
    chk("fwd_eq_op2", bus.alu_op2, 32'd1);
    wb_q.push_back('{4'd5, 32'd1});
    chk("fwd_eq_flags", 32'(bus.flags_nzcv), 32'b0110);
    @(posedge clk); #1;

    send(32'hE1500000, 3, 4);
    send(32'h03A05001, 0, 0);
    chk("fwd_ne_bubble", 32'(bus.alu_valid), 32'd0);
    chk("fwd_ne_flags", 32'(bus.flags_nzcv), 32'b1000);
    @(posedge clk); #1;

    // Reset while an RSR instruction waits in RS_FETCH
    send(32'hE1B00211, 0, 1);
    chk("rst_mid_in_fetch", 32'(bus.instr_ready), 32'd0);
    bus.instr = 32'hE3B01000;
    bus.instr_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_alu_valid", 32'(bus.alu_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_mid_flags", 32'(bus.flags_nzcv), 32'd0);
    chk("rst_mid_rs_addr", 32'(bus.rs_addr), 32'd0);
    @(posedge clk); #1;
    chk("rst_held_alu_valid", 32'(bus.alu_valid), 32'd0);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_alu_valid", 32'(bus.alu_valid), 32'd0);
    chk("rst_after_ready", 32'(bus.instr_ready), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
